// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - five-stage pipeline hazard controller with mult/div busy counter
module hazard_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic       BranchD,
  input  logic       MDUseD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic       MDStartE,
  input  logic       MDTypeE,
  input  logic [4:0] WriteRegM,
  input  logic       RegWriteM,
  input  logic       MemtoRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteW,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       ForwardA_D,
  output logic       ForwardB_D,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       MDBusy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  logic lwstall;
  logic brstall;
  logic mdstall;
  logic stall;

  // A write to $0 is discarded, so it can never be a hazard source.
  function automatic logic reg_match(input logic en, input logic [4:0] dst, input logic [4:0] src);
    return en && (dst != 5'd0) && (dst == src);
  endfunction

  // ALU operand forwarding: the younger producer in M wins over W.
  always_comb begin
    ForwardA_E = FWD_REG;
    ForwardB_E = FWD_REG;
    if (reg_match(RegWriteM, WriteRegM, RsE))
      ForwardA_E = FWD_M;
    else if (reg_match(RegWriteW, WriteRegW, RsE))
      ForwardA_E = FWD_W;
    if (reg_match(RegWriteM, WriteRegM, RtE))
      ForwardB_E = FWD_M;
    else if (reg_match(RegWriteW, WriteRegW, RtE))
      ForwardB_E = FWD_W;
  end

  // Branch comparator in D can only take the ALU result sitting in M.
  always_comb begin
    ForwardA_D = reg_match(RegWriteM, WriteRegM, RsD);
    ForwardB_D = reg_match(RegWriteM, WriteRegM, RtD);
  end

  // Stall sources: load-use, branch operand not yet available, mult/div in flight.
  always_comb begin
    lwstall = reg_match(MemtoRegE, WriteRegE, RsD) ||
              reg_match(MemtoRegE, WriteRegE, RtD);
    brstall = BranchD &&
              (reg_match(RegWriteE, WriteRegE, RsD) ||
               reg_match(RegWriteE, WriteRegE, RtD) ||
               reg_match(MemtoRegM, WriteRegM, RsD) ||
               reg_match(MemtoRegM, WriteRegM, RtD));
    mdstall = MDUseD && (MDBusy || MDStartE);
    stall   = lwstall || brstall || mdstall;
    StallF  = stall;
    StallD  = stall;
    FlushE  = stall;
  end

  // Mult/div busy counter: loaded on a start from idle, counts down to zero; restarts while busy are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MDStartE) begin
            count <= MDTypeE ? DIV_LOAD : MULT_LOAD;
            state <= BUSY;
          end
        end
        BUSY: begin
          count <= count - CNT_ONE;
          if (count == CNT_ONE)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Busy is exactly "counter not yet drained".
  always_comb begin
    MDBusy = (count != '0);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       BranchD, MDUseD, RegWriteE, MemtoRegE, MDStartE, MDTypeE;
  logic       RegWriteM, MemtoRegM, RegWriteW;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       ForwardA_D, ForwardB_D, StallF, StallD, FlushE, MDBusy;

  hazard_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .MDUseD(MDUseD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MDStartE(MDStartE), .MDTypeE(MDTypeE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .MDBusy(MDBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic       branchd, mdused, rwe, mre, rwm, mrm, rww;
    logic [1:0] fa_e, fb_e;
    logic       fa_d, fb_d, stall;
  } vec_t;

  vec_t vq[$];
  int   tests  = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   md_start = -100;
  int   md_end   = -100;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] fa_e, input logic [1:0] fb_e,
                            input logic fa_d, input logic fb_d, input logic stall, input logic busy);
    check({tag, ".ForwardA_E"}, ForwardA_E, fa_e);
    check({tag, ".ForwardB_E"}, ForwardB_E, fb_e);
    check({tag, ".ForwardA_D"}, {1'b0, ForwardA_D}, {1'b0, fa_d});
    check({tag, ".ForwardB_D"}, {1'b0, ForwardB_D}, {1'b0, fb_d});
    check({tag, ".StallF"}, {1'b0, StallF}, {1'b0, stall});
    check({tag, ".StallD"}, {1'b0, StallD}, {1'b0, stall});
    check({tag, ".FlushE"}, {1'b0, FlushE}, {1'b0, stall});
    check({tag, ".MDBusy"}, {1'b0, MDBusy}, {1'b0, busy});
  endtask

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    BranchD = 0; MDUseD = 0; RegWriteE = 0; MemtoRegE = 0; MDStartE = 0; MDTypeE = 0;
    RegWriteM = 0; MemtoRegM = 0; RegWriteW = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    RsD = v.rsd; RtD = v.rtd; RsE = v.rse; RtE = v.rte;
    WriteRegE = v.wre; WriteRegM = v.wrm; WriteRegW = v.wrw;
    BranchD = v.branchd; MDUseD = v.mdused; RegWriteE = v.rwe; MemtoRegE = v.mre;
    RegWriteM = v.rwm; MemtoRegM = v.mrm; RegWriteW = v.rww;
    MDStartE = 0; MDTypeE = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: a producer is visible only when it writes a nonzero register equal to the source.
  function automatic logic hit(input logic en, input logic [4:0] dst, input logic [4:0] src);
    return en && dst != 0 && dst == src;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (hit(RegWriteM, WriteRegM, src)) return 2'd2;
    if (hit(RegWriteW, WriteRegW, src)) return 2'd1;
    return 2'd0;
  endfunction

  // Unit is busy in the cycles strictly after the accepted start, through start+N.
  function automatic logic ref_busy(input int c);
    return (c > md_start) && (c <= md_end);
  endfunction

  task automatic mult_div_run(input string tag, input logic is_div, input int n);
    next_cycle();
    clear_inputs();
    MDStartE = 1; MDTypeE = is_div; MDUseD = 1;
    @(negedge clk);
    check_outs({tag, "_c0"}, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= n + 1; k++) begin
      next_cycle();
      MDStartE = 0;
      @(negedge clk);
      check_outs($sformatf("%s_c%0d", tag, k), 0, 0, 0, 0, (k <= n), (k <= n));
    end
  endtask

  vec_t v;
  int   start_c;

  initial begin
    clear_inputs();
    reset = 0;
    #3;
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    next_cycle();
    reset = 1;

    v = '0; v.rwm = 1; v.wrm = 8; v.rww = 1; v.wrw = 8; v.rse = 8; v.rte = 9; v.fa_e = 2; vq.push_back(v);
    v = '0; v.rww = 1; v.wrw = 8; v.rse = 8; v.rte = 9; v.fa_e = 1; vq.push_back(v);
    v = '0; v.rwm = 1; v.wrm = 0; v.rse = 0; v.rsd = 0; vq.push_back(v);
    v = '0; v.mre = 1; v.rwe = 1; v.wre = 5; v.rtd = 5; v.stall = 1; vq.push_back(v);
    v = '0; v.mre = 1; v.rwe = 1; v.wre = 5; v.rtd = 6; vq.push_back(v);
    v = '0; v.branchd = 1; v.rsd = 3; v.rwe = 1; v.wre = 3; v.stall = 1; vq.push_back(v);
    v = '0; v.branchd = 1; v.rsd = 3; v.rwm = 1; v.wrm = 3; v.fa_d = 1; vq.push_back(v);
    v = '0; v.branchd = 1; v.rtd = 3; v.rwm = 1; v.mrm = 1; v.wrm = 3; v.fb_d = 1; v.stall = 1; vq.push_back(v);
    v = '0; v.rww = 1; v.wrw = 7; v.rte = 7; v.fb_e = 1; vq.push_back(v);
    v = '0; v.mre = 1; v.wre = 0; v.rsd = 0; vq.push_back(v);
    v = '0; v.branchd = 1; v.rwe = 1; v.wre = 0; v.rsd = 0; vq.push_back(v);
    v = '0; v.rwm = 1; v.wrm = 4; v.rtd = 4; v.rte = 4; v.fb_d = 1; v.fb_e = 2; vq.push_back(v);
    v = '0; v.rwe = 1; v.wre = 9; v.rsd = 9; vq.push_back(v);

    foreach (vq[i]) begin
      next_cycle();
      drive_vec(vq[i]);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vq[i].fa_e, vq[i].fb_e, vq[i].fa_d, vq[i].fb_d, vq[i].stall, 0);
    end

    mult_div_run("div", 1'b1, DIV_N);
    mult_div_run("mult", 1'b0, MULT_N);

    // Reset partway through a div drops busy and the stall without a clock edge.
    next_cycle();
    clear_inputs();
    MDStartE = 1; MDTypeE = 1; MDUseD = 1;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      MDStartE = 0;
    end
    #2;
    reset = 0;
    #1;
    check_outs("rst_mid", 0, 0, 0, 0, 0, 0);
    reset = 1;
    next_cycle();
    @(negedge clk);
    check_outs("rst_after", 0, 0, 0, 0, 0, 0);
    mult_div_run("mult_after_rst", 1'b0, MULT_N);

    // Randomized traffic against the reference model.
    md_start = -100;
    md_end   = -100;
    for (int n = 0; n < 600; n++) begin
      next_cycle();
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      BranchD = 1'($urandom_range(0, 1)); MDUseD = 1'($urandom_range(0, 1));
      RegWriteE = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1)); MemtoRegM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MDStartE = ($urandom_range(0, 7) == 0); MDTypeE = 1'($urandom_range(0, 1));
      @(negedge clk);
      begin
        logic lw, br, md, busy;
        busy = ref_busy(cyc);
        lw = hit(MemtoRegE, WriteRegE, RsD) || hit(MemtoRegE, WriteRegE, RtD);
        br = BranchD && (hit(RegWriteE, WriteRegE, RsD) || hit(RegWriteE, WriteRegE, RtD) ||
                         hit(MemtoRegM, WriteRegM, RsD) || hit(MemtoRegM, WriteRegM, RtD));
        md = MDUseD && (busy || MDStartE);
        check_outs("rand", ref_fwd(RsE), ref_fwd(RtE), hit(RegWriteM, WriteRegM, RsD),
                   hit(RegWriteM, WriteRegM, RtD), lw || br || md, busy);
        if (MDStartE && !busy) begin
          start_c  = cyc;
          md_start = start_c;
          md_end   = start_c + (MDTypeE ? DIV_N : MULT_N);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage core. Each cycle it generates the execute-stage forwarding selects that drive the ALU A/B operand muxes and the decode-stage branch-compare forwarding selects. It also produces the fetch/decode stall and execute flush signals. It owns the busy counter for the multi-cycle mult/div unit and stalls any HI/LO or mult/div consumer until that unit has finished.

## Interface
- MULT_CYCLES, 5: busy cycles after a mult starts (1..2^CNT_W-1)
- DIV_CYCLES, 10: busy cycles after a div starts (1..2^CNT_W-1)
- CNT_W, 5: busy counter width
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears busy counter
- RsD, RtD  input  5 each  source registers of decode-stage instruction
- BranchD  input  1  decode instruction is a branch comparing Rs/Rt in D
- MDUseD  input  1  decode instruction is mult/div/mfhi/mflo/mthi/mtlo
- RsE, RtE  input  5 each  source registers of execute-stage instruction
- WriteRegE  input  5  destination register in E
- RegWriteE, MemtoRegE  input  1 each  E writes a register / E is a load
- MDStartE  input  1  E instruction starts the mult/div unit this cycle
- MDTypeE  input  1  0 = mult, 1 = div (valid with MDStartE)
- WriteRegM  input  5  destination register in M
- RegWriteM, MemtoRegM  input  1 each  M writes a register / M is a load
- WriteRegW  input  5  destination register in W
- RegWriteW  input  1  W writes a register
- ForwardA_E, ForwardB_E  output  2 each  ALU operand select: 00 register file, 01 ResultW, 10 ALU_O_M; 11 never driven
- ForwardA_D, ForwardB_D  output  1 each  branch comparator takes ALU_O_M instead of register file
- StallF, StallD  output  1 each  hold PC / hold IF-ID register
- FlushE  output  1  load bubble into ID-EX register
- MDBusy  output  1  mult/div unit busy (counter nonzero)

## Operation
- Register $0 never matches: any comparison where the destination is 0 is false.
- ForwardA_E:
  - 10 if RegWriteM and WriteRegM==RsE.
  - Otherwise 01 if RegWriteW and WriteRegW==RsE.
  - Otherwise 00.
  - M has priority over W. ForwardB_E is identical using RtE.
- ForwardA_D = RegWriteM and WriteRegM==RsD (nonzero). ForwardB_D is the same using RtD.
- lwstall = MemtoRegE and WriteRegE matches RsD or RtD.
- brstall = BranchD and either:
  - RegWriteE and WriteRegE matches RsD/RtD, or
  - MemtoRegM and WriteRegM matches RsD/RtD.
- mdstall = MDUseD and (MDBusy or MDStartE).
- StallF = StallD = FlushE = lwstall | brstall | mdstall.
- Busy counter FSM, with states IDLE (count==0) and BUSY (count!=0):
  - IDLE and MDStartE: load MULT_CYCLES or DIV_CYCLES per MDTypeE, go to BUSY.
  - BUSY: decrement by 1 each cycle; return to IDLE at 0.
  - MDStartE while BUSY: ignored, counter not reloaded. The stall logic makes this unreachable in legal operation.
- MDBusy = (count != 0).

## Timing
- Forwarding, stall and flush outputs are purely combinational from the current-cycle inputs and the counter; there are zero cycles of latency.
- Only the counter is registered.
- MDStartE high in cycle t causes:
  - count = N at the edge ending t.
  - MDBusy high in cycles t+1 .. t+N.
  - A consumer in D is stalled in cycles t .. t+N and proceeds in t+N+1.
- Reset (async, low): count = 0 immediately, and MDBusy = 0.
  - Combinational outputs then follow the inputs; with all inputs 0 they read ForwardX = 00 and stalls/flush = 0.
  - Reset mid-operation abandons the mult/div and releases the stall.
- Simultaneous lwstall and mdstall produce a single stall; the counter still decrements during stall cycles.

## Test plan
- ALU forwarding with M priority:
  - RegWriteM=1, WriteRegM=8; RegWriteW=1, WriteRegW=8; RsE=8, RtE=9 -> ForwardA_E=10, ForwardB_E=00.
  - Then RegWriteM=0 -> ForwardA_E=01.
- $0 suppression: RegWriteM=1, WriteRegM=0, RsE=0 -> ForwardA_E=00 and ForwardA_D=0.
- Load-use: MemtoRegE=1, WriteRegE=5, RtD=5 -> StallF=StallD=FlushE=1 for exactly that cycle. With RtD=6 -> all 0.
- Branch hazard:
  - BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 -> stall.
  - Next cycle, same register now in M (RegWriteM=1, MemtoRegM=0) -> no stall, ForwardA_D=1.
- Div busy:
  - MDStartE=1, MDTypeE=1 at cycle 0 -> MDBusy high in cycles 1..10.
  - MDUseD=1 held -> stall in cycles 0..10, released in cycle 11. With MULT_CYCLES=5, release is in cycle 6.
- Reset mid-div: assert reset low at cycle 4 of a div -> MDBusy=0 and stall=0 asynchronously. After release, a new MDStartE reloads the counter normally.
